// File: rtl/ad1xx_mem_arbiter.sv
// ad1xx memory arbiter: shares one byte-wide RAM port between the fetch
// and load/store ports, sequencing each word as four little-endian beats.
module ad1xx_mem_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic              owner_d;
  logic              last_d;
  logic              we;
  logic              gnt_i;
  logic              gnt_d;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [ADDR_W-3:0] word;
  logic [1:0]        beat;
  logic [23:0]       rbuf;
  logic              unused_addr;

  assign unused_addr = ^{i_addr[1:0], d_addr[1:0]};

  // last_d resets high so fetch wins the first tie
  assign gnt_i = i_req && (!d_req || last_d);
  assign gnt_d = d_req && !gnt_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (i_req || d_req) state_nx = XFER;
      XFER:    if (beat == 2'd3) state_nx = we ? DONE : DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    unique case (1'b1)
      (state == XFER): begin
        mem_en   = 1'b1;
        mem_we   = we && be[beat];
        mem_addr = {word, beat};
        if (we) mem_wdata = wdata[{beat, 3'b000} +: 8];
      end
      (state == DONE): begin
        i_ack = !owner_d;
        d_ack = owner_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_d <= 1'b0;
      last_d  <= 1'b1;
      we      <= 1'b0;
      be      <= 4'h0;
      wdata   <= '0;
      word    <= '0;
      beat    <= 2'd0;
      rbuf    <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner_d <= gnt_d;
            we      <= gnt_d && d_we;
            be      <= gnt_d ? d_be : 4'h0;
            wdata   <= gnt_d ? d_wdata : 32'h0;
            word    <= gnt_d ? d_addr[ADDR_W-1:2]
                             : i_addr[ADDR_W-1:2];
            beat    <= 2'd0;
          end
        end
        XFER: begin
          beat <= beat + 2'd1;
          // read data trails the strobe by one cycle
          if (!we && beat != 2'd0)
            rbuf <= {mem_rdata, rbuf[23:8]};
        end
        DRAIN: begin
          if (owner_d) d_rdata <= {mem_rdata, rbuf};
          else         i_rdata <= {mem_rdata, rbuf};
        end
        DONE:    last_d <= owner_d;
        default: ;
      endcase
    end
  end

endmodule
